sub_bytes_engine: RTL and testbench

Multi-cycle forward AES SubBytes engine. It takes a 128-bit state and substitutes every byte with the forward AES S-box, LANES bytes per cycle. It is the encrypt-direction counterpart of the existing inverse S-box datapath and uses the same composite-field GF((2^4)^2) arithmetic. It sits between the round-key/ShiftRows logic and MixColumns in the encryption round. Both ends use valid/ready handshakes.

---
 rtl/sub_bytes_engine.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sub_bytes_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// Multi-cycle forward AES SubBytes engine. LANES composite-field S-box lanes
// walk the latched 128-bit state group by group; an optional register after
// the GF(2^4) inversion splits each lane in two.
module sub_bytes_engine #(
    parameter int unsigned LANES = 4,
    parameter int unsigned PIPE  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [7:0] AFF_C = 8'h63;

    // GF(2^4) multiply modulo x^4 + x + 1.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // x^14 = x^-1 for x != 0, and maps 0 to 0.
    function automatic logic [3:0] gf4_inv(input logic [3:0] x);
        logic [3:0] x2;
        logic [3:0] x4;
        logic [3:0] x8;
        x2 = gf4_mul(x, x);
        x4 = gf4_mul(x2, x2);
        x8 = gf4_mul(x4, x4);
        return gf4_mul(gf4_mul(x8, x4), x2);
    endfunction

    // Smallest lambda making y^2 + y + lambda irreducible over GF(2^4).
    function automatic logic [3:0] find_lambda();
        logic [3:0] lam;
        logic       found;
        logic       ok;
        lam   = 4'h0;
        found = 1'b0;
        for (int c = 1; c < 16; c++) begin
            ok = 1'b1;
            for (int t = 0; t < 16; t++) begin
                if ((gf4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(c)) ok = 1'b0;
            end
            if (ok && !found) begin
                lam   = 4'(c);
                found = 1'b1;
            end
        end
        return lam;
    endfunction

    // Multiply in GF((2^4)^2), element {h, l} = h*Y + l with Y^2 = Y + lambda.
    function automatic logic [7:0] comp_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] lam);
        logic [3:0] hh;
        logic [3:0] h;
        logic [3:0] l;
        hh = gf4_mul(a[7:4], b[7:4]);
        h  = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
        l  = gf4_mul(hh, lam) ^ gf4_mul(a[3:0], b[3:0]);
        return {h, l};
    endfunction

    // Isomorphism columns: AES basis x^i maps to z^i, z a composite root of 0x11b.
    function automatic logic [63:0] find_iso(input logic [3:0] lam);
        logic [7:0]  zz, z2, z3, z4, z8, root, acc;
        logic [63:0] cols;
        logic        found;
        root  = 8'h02;
        found = 1'b0;
        for (int z = 2; z < 256; z++) begin
            zz = 8'(z);
            z2 = comp_mul(zz, zz, lam);
            z3 = comp_mul(z2, zz, lam);
            z4 = comp_mul(z2, z2, lam);
            z8 = comp_mul(z4, z4, lam);
            if (!found && ((z8 ^ z4 ^ z3 ^ zz ^ 8'h01) == 8'h00)) begin
                root  = zz;
                found = 1'b1;
            end
        end
        acc  = 8'h01;
        cols = 64'h0;
        for (int i = 0; i < 8; i++) begin
            cols = cols | (64'(acc) << (8 * i));
            acc  = comp_mul(acc, root, lam);
        end
        return cols;
    endfunction

    // Apply a GF(2)-linear map given as eight 8-bit columns.
    function automatic logic [7:0] lin_map(input logic [7:0] x, input logic [63:0] cols);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ 8'(cols >> (8 * i));
        end
        return r;
    endfunction

    // Inverse map columns: preimage of each composite unit vector.
    function automatic logic [63:0] find_iso_inv(input logic [63:0] cols);
        logic [63:0] inv;
        inv = 64'h0;
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < 256; a++) begin
                if (lin_map(8'(a), cols) == (8'h01 << k)) inv = inv | (64'(a) << (8 * k));
            end
        end
        return inv;
    endfunction

    localparam logic [3:0]  LAMBDA  = find_lambda();
    localparam logic [63:0] ISO     = find_iso(LAMBDA);
    localparam logic [63:0] ISO_INV = find_iso_inv(ISO);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  src_q, src_d;
    logic [127:0]  res_q, res_d;
    logic          out_valid_q;

    logic [LANES-1:0][11:0] stg_a;   // {delta^-1, h, l} per lane
    logic [LANES-1:0][11:0] stg_b;
    logic [LANES-1:0][7:0]  lane_out;
    logic [CW-1:0]          wbase;
    logic                   wen;

    // Front half of each lane: map into the composite field and invert the norm.
    always_comb begin
        logic [7:0] b;
        logic [7:0] x;
        logic [3:0] d;
        int         sb;
        stg_a = '0;
        sb    = int'(cnt_q) * int'(LANES);
        for (int j = 0; j < int'(LANES); j++) begin
            b        = src_q[(sb + j) * 8 +: 8];
            x        = lin_map(b, ISO);
            d        = gf4_mul(gf4_mul(x[7:4], x[7:4]), LAMBDA) ^ gf4_mul(x[7:4] ^ x[3:0], x[3:0]);
            stg_a[j] = {gf4_inv(d), x[7:4], x[3:0]};
        end
    end

    if (PIPE != 0) begin : g_pipe
        logic [LANES-1:0][11:0] stg_q;
        logic [CW-1:0]          wcnt_q;
        logic                   wr_vld_q;

        // Lane stage register; the write slot trails the issue slot by one cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_q    <= '0;
                wcnt_q   <= '0;
                wr_vld_q <= 1'b0;
            end else begin
                stg_q    <= stg_a;
                wcnt_q   <= cnt_q;
                wr_vld_q <= (state_q == StRun);
            end
        end

        assign stg_b = stg_q;
        assign wbase = wcnt_q;
        assign wen   = wr_vld_q;
    end else begin : g_comb
        assign stg_b = stg_a;
        assign wbase = cnt_q;
        assign wen   = (state_q == StRun);
    end

    // Back half of each lane: multiply back, map out, forward affine.
    always_comb begin
        logic [3:0] h;
        logic [3:0] l;
        logic [7:0] y;
        lane_out = '0;
        for (int j = 0; j < int'(LANES); j++) begin
            h = gf4_mul(stg_b[j][7:4], stg_b[j][11:8]);
            l = gf4_mul(stg_b[j][7:4] ^ stg_b[j][3:0], stg_b[j][11:8]);
            y = lin_map({h, l}, ISO_INV);
            for (int k = 0; k < 8; k++) begin
                lane_out[j][k] = y[k] ^ y[(k + 4) % 8] ^ y[(k + 5) % 8] ^ y[(k + 6) % 8]
                               ^ y[(k + 7) % 8] ^ AFF_C[k];
            end
        end
    end

    // Sequencer next state: accept, issue N groups, optional drain, hold result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    src_d   = in_data;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == LAST) state_d = (PIPE != 0) ? StDrain : StDone;
                else               cnt_d   = cnt_q + CW'(1);
            end
            StDrain: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result slot update for the group currently leaving the lanes.
    always_comb begin
        int wb;
        res_d = res_q;
        wb    = int'(wbase) * int'(LANES);
        if (wen) begin
            for (int j = 0; j < int'(LANES); j++) res_d[(wb + j) * 8 +: 8] = lane_out[j];
        end
    end

    // State, counter, source/result and registered out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            src_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            res_q       <= res_d;
            out_valid_q <= (state_d == StDone);
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign out_valid = out_valid_q;
    assign out_data  = res_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench: ten engines (every LANES x PIPE) share one stimulus list;
// each has its own driver pushing expectations and a monitor popping them.
`timescale 1ns/1ps
module tb_sub_bytes_engine;

    localparam int NCFG  = 10;
    localparam int NSTIM = 24;

    typedef struct {
        logic [127:0] exp;
        logic [127:0] src;
        int           acc;
    } item_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] stim [NSTIM];
    logic [127:0] expv [NSTIM];

    logic [NCFG-1:0] ov, bz, ir;
    logic [127:0]    od [NCFG];
    bit go1, go2, go3;
    bit done1 [NCFG];
    bit done3 [NCFG];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input int c, input string name, input bit ok,
                         input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cfg%0d: actual %h required %h", name, c, act, req);
        end
    endtask

    // Reference S-box from plain GF(2^8) arithmetic modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox[d[8*i +: 8]];
        return r;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int L   = 1 << (g / 2);
        localparam int P   = g % 2;
        localparam int LAT = 16 / L + P;

        logic         in_valid;
        logic         out_ready;
        logic [127:0] in_data;
        item_t        q [$];
        int           last_hs;

        sub_bytes_engine #(.LANES(L), .PIPE(P)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .busy      (bz[g])
        );

        task automatic send(input logic [127:0] d, input logic [127:0] e);
            int    start;
            bit    ok;
            item_t it;
            ok       = 0;
            in_data  = d;
            in_valid = 1'b1;
            start    = cyc;
            for (int t = 0; t < 400; t++) begin
                if (ir[g]) begin
                    ok     = 1;
                    it.exp = e;
                    it.src = d;
                    it.acc = cyc + 1;
                    q.push_back(it);
                    if (last_hs >= start)
                        check(g, "accept_after_handshake", (cyc + 1) == last_hs + 1,
                              128'(cyc + 1), 128'(last_hs + 1));
                    break;
                end
                @(negedge clk);
            end
            if (!ok) check(g, "accept_timeout", 1'b0, 128'(0), 128'(1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        endtask

        task automatic drain();
            bit ok;
            ok = 0;
            for (int t = 0; t < 500; t++) begin
                if (q.size() == 0 && !ov[g]) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            check(g, "drain", ok, 128'(q.size()), 128'(0));
        endtask

        // Driver
        initial begin
            item_t it;
            int    gap;
            in_valid = 1'b0;
            in_data  = '0;
            done1[g] = 0;
            done3[g] = 0;
            wait (go1);
            @(negedge clk);
            for (int i = 0; i < NSTIM; i++) begin
                send(stim[i], expv[i]);
                gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
                repeat (gap) @(negedge clk);
            end
            drain();
            done1[g] = 1;
            wait (go2);
            in_data  = stim[2];
            in_valid = 1'b1;
            it.exp   = expv[2];
            it.src   = stim[2];
            it.acc   = cyc + 1;
            q.push_back(it);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait (go3);
            send(stim[1], expv[1]);
            send(stim[NSTIM-1], expv[NSTIM-1]);
            drain();
            done3[g] = 1;
        end

        // Monitor
        initial begin
            bit           seen;
            bit           rt;
            int           hold;
            logic [127:0] held;
            logic [127:0] o;
            item_t        it;
            seen      = 0;
            hold      = 0;
            held      = '0;
            last_hs   = -1;
            out_ready = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    seen      = 0;
                    hold      = 0;
                    out_ready = 1'b0;
                    q.delete();
                    continue;
                end
                if (ov[g]) begin
                    o = od[g];
                    if (!seen) begin
                        seen = 1;
                        held = o;
                        hold = ($urandom_range(0, 3) == 0) ? 5 : int'($urandom_range(0, 2));
                        if (q.size() == 0) begin
                            check(g, "unexpected_output", 1'b0, o, 128'(0));
                        end else begin
                            it = q.pop_front();
                            check(g, "data", o == it.exp, o, it.exp);
                            check(g, "latency", (cyc - it.acc) == LAT, 128'(cyc - it.acc),
                                  128'(LAT));
                            rt = 1;
                            for (int i = 0; i < 16; i++)
                                if (inv_sbox[o[8*i +: 8]] != it.src[8*i +: 8]) rt = 0;
                            check(g, "roundtrip", rt, o, it.src);
                        end
                    end else begin
                        check(g, "out_data_stable", o == held, o, held);
                        check(g, "in_ready_in_done", ir[g] == 1'b0, 128'(ir[g]), 128'(0));
                        check(g, "busy_in_done", bz[g] == 1'b0, 128'(bz[g]), 128'(0));
                    end
                    if (hold == 0) begin
                        out_ready = 1'b1;
                        last_hs   = cyc + 1;
                        seen      = 0;
                    end else begin
                        hold--;
                        out_ready = 1'b0;
                    end
                end else begin
                    if (seen) check(g, "valid_dropped", 1'b0, 128'(0), 128'(1));
                    seen      = 0;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NCFG; k++) begin
            check(k, {tag, "_out_valid"}, ov[k] == 1'b0, 128'(ov[k]), 128'(0));
            check(k, {tag, "_busy"}, bz[k] == 1'b0, 128'(bz[k]), 128'(0));
            check(k, {tag, "_in_ready"}, ir[k] == 1'b1, 128'(ir[k]), 128'(1));
            check(k, {tag, "_out_data"}, od[k] == '0, od[k], 128'(0));
        end
    endtask

    function automatic int count_done(input int phase);
        int n;
        n = 0;
        for (int k = 0; k < NCFG; k++) n += (phase == 1) ? int'(done1[k]) : int'(done3[k]);
        return n;
    endfunction

    initial begin
        logic [7:0] inv;
        int         n;
        checks = 0;
        errors = 0;
        go1    = 0;
        go2    = 0;
        go3    = 0;
        rst_n  = 1'b0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_sbox[sbox[x]] = 8'(x);

        stim[0] = '0;
        expv[0] = {16{8'h63}};
        stim[1] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        expv[1] = 128'h76abd7fe_2b670130_c56f6bf2_7b777c63;
        stim[2] = {2{64'h0052ff53_bee33d19}};
        expv[2] = {2{64'h630016ed_ae1127d4}};
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) stim[3+k][8*i +: 8] = 8'(16 * k + i);
            expv[3+k] = model(stim[3+k]);
        end
        for (int k = 19; k < NSTIM; k++) begin
            stim[k] = {$urandom, $urandom, $urandom, $urandom};
            expv[k] = model(stim[k]);
        end

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        go1   = 1;

        n = 0;
        for (int t = 0; t < 30000; t++) begin
            @(negedge clk);
            n = count_done(1);
            if (n == NCFG) break;
        end
        check(0, "phase1_done", n == NCFG, 128'(n), 128'(NCFG));

        // Abort a state in flight: reset lands while the LANES=2 engines sit at cnt = 2.
        @(negedge clk);
        go2 = 1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrun_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        go3 = 1;

        n = 0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            n = count_done(3);
            if (n == NCFG) break;
        end
        check(0, "phase3_done", n == NCFG, 128'(n), 128'(NCFG));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
